demux_frame_driver: RTL and testbench

- Upstream stage for the 1-to-4 demultiplexer (`Dem14`). Accepts parallel words tagged with a 2-bit channel id over a valid/ready handshake.
- Serializes each word onto the demux data input `a`. Drives the demux selects `s1`/`s2` so that every bit of the word appears on exactly one of outputs A/B/C/D.
- Replaces free-running toggle stimulus with framed, deterministic traffic.

---
 rtl/dmx_pkg.sv | 17 +
 rtl/dmx_piso.sv | 31 +++
 rtl/demux_frame_driver.sv | 127 ++++++++++++
 tb/tb_demux_frame_driver.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// Shared types for the demux frame driver.
// FSM state encoding and demux channel ids.
package dmx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

endpackage

// File: rtl/dmx_piso.sv
// Parallel-load, serial-out shift register.
// The bit presented on dout is always the next payload bit to send.
module dmx_piso
    import dmx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    output logic              dout
);

    logic [DATA_W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift_en) begin
            sr <= (MSB_FIRST != 0) ? (sr << 1) : (sr >> 1);
        end
    end

    assign dout = (MSB_FIRST != 0) ? sr[DATA_W-1] : sr[0];

endmodule

// File: rtl/demux_frame_driver.sv
// Frames channel-tagged words into serial traffic for a 1-to-4 demux.
// Selects settle for one cycle before data, and hold while idle.
module demux_frame_driver
    import dmx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int GAP_CYC   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              a,
    output logic              s1,
    output logic              s2,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [GAP_W-1:0] gcnt, gcnt_nxt;
    logic [1:0]       sel_nxt;
    logic             a_nxt, done_nxt;
    logic             load, shift_en, piso_bit, accept;

    assign accept = in_valid & in_ready;

    dmx_piso #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .shift_en (shift_en),
        .din      (in_data),
        .dout     (piso_bit)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gcnt_nxt  = gcnt;
        sel_nxt   = {s1, s2};
        a_nxt     = 1'b0;
        done_nxt  = 1'b0;
        load      = 1'b0;
        shift_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    sel_nxt   = in_ch;
                    load      = 1'b1;
                end
            end
            SETUP: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SHIFT;
                    cnt_nxt   = CNT_W'(DATA_W - 1);
                    a_nxt     = piso_bit;
                    shift_en  = 1'b1;
                end
            end
            SHIFT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    done_nxt = 1'b1;
                    if (GAP_CYC > 0) begin
                        state_nxt = GAP;
                        gcnt_nxt  = GAP_W'(GAP_CYC - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt  = cnt - 1'b1;
                    a_nxt    = piso_bit;
                    shift_en = 1'b1;
                end
            end
            GAP: begin
                if (flush || gcnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gcnt_nxt = gcnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so nothing is combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            gcnt     <= '0;
            a        <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            gcnt     <= gcnt_nxt;
            a        <= a_nxt;
            {s1, s2} <= sel_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= done_nxt;
            in_ready <= (state_nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_demux_frame_driver.sv
// Directed bench for demux_frame_driver.
// Two instances: MSB-first with one gap cycle, LSB-first with no gap.
module tb_demux_frame_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid, in_ready, flush, a, s1, s2, busy, done;
    logic [1:0] in_ch;
    logic [7:0] in_data;

    logic       v1_valid, v1_ready, v1_flush, v1_a, v1_s1, v1_s2, v1_busy, v1_done;
    logic [1:0] v1_ch;
    logic [7:0] v1_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_frame_driver #(
        .DATA_W (8), .GAP_CYC (1), .MSB_FIRST (1)
    ) u_dut0 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready),
        .in_ch (in_ch), .in_data (in_data), .flush (flush),
        .a (a), .s1 (s1), .s2 (s2), .busy (busy), .done (done)
    );

    demux_frame_driver #(
        .DATA_W (8), .GAP_CYC (0), .MSB_FIRST (0)
    ) u_dut1 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (v1_valid), .in_ready (v1_ready),
        .in_ch (v1_ch), .in_data (v1_data), .flush (v1_flush),
        .a (v1_a), .s1 (v1_s1), .s2 (v1_s2), .busy (v1_busy), .done (v1_done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full word on instance 0, then next inputs presented while busy.
    task automatic send0(input logic [1:0] ch, input logic [7:0] d,
                         input logic [7:0] exp_ser, input logic [1:0] nch,
                         input logic [7:0] nd, input logic nvalid);
        logic [7:0]  ser;
        logic [7:0]  lane [4];
        logic [31:0] lanes_exp;
        ser = '0;
        for (int l = 0; l < 4; l++) lane[l] = '0;
        check("ready_pre", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        tick();
        in_valid = nvalid;
        in_ch    = nch;
        in_data  = nd;
        check("setup_sel", 32'({s1, s2}), 32'(ch));
        check("setup_a", 32'(a), 32'd0);
        check("setup_rdy", 32'({in_ready, busy}), 32'b01);
        for (int i = 0; i < 8; i++) begin
            tick();
            ser = {ser[6:0], a};
            for (int l = 0; l < 4; l++)
                lane[l] = {lane[l][6:0], a & ({s1, s2} == 2'(l))};
            check("shift_sel", 32'({s1, s2}), 32'(ch));
            check("shift_rdy_done", 32'({in_ready, done}), 32'b00);
        end
        check("serial", 32'(ser), 32'(exp_ser));
        lanes_exp = 32'(exp_ser) << (32'(ch) * 8);
        check("lanes", {lane[3], lane[2], lane[1], lane[0]}, lanes_exp);
        tick();
        check("gap_done", 32'(done), 32'd1);
        check("gap_a_rdy", 32'({a, in_ready}), 32'b00);
        tick();
        check("idle_done", 32'(done), 32'd0);
        check("idle_rdy_busy", 32'({in_ready, busy}), 32'b10);
    endtask

    initial begin : main
        logic [7:0] ser;
        in_valid = 1'b0; in_ch = '0; in_data = '0; flush = 1'b0;
        v1_valid = 1'b0; v1_ch = '0; v1_data = '0; v1_flush = 1'b0;

        #2;
        check("rst_outs0", 32'({a, s1, s2, busy, done, in_ready}), 32'd0);
        check("rst_outs1", 32'({v1_a, v1_s1, v1_s2, v1_busy, v1_done, v1_ready}), 32'd0);
        #10 rst_n = 1'b1;
        #1;
        check("rdy_before_edge", 32'(in_ready), 32'd0);
        tick();
        check("rdy_after_edge", 32'({in_ready, v1_ready}), 32'b11);

        // Channel C, A5
        send0(2'b10, 8'hA5, 8'hA5, 2'b00, 8'h00, 1'b0);

        // Back-to-back: FF on A, then 01 on D held valid while busy
        send0(2'b00, 8'hFF, 8'hFF, 2'b11, 8'h01, 1'b1);
        send0(2'b11, 8'h01, 8'h01, 2'b00, 8'h00, 1'b0);

        // LSB-first, no gap, channel B, data 03
        check("i1_rdy", 32'(v1_ready), 32'd1);
        v1_valid = 1'b1; v1_ch = 2'b01; v1_data = 8'h03;
        tick();
        v1_valid = 1'b0; v1_data = 8'hFF;
        check("i1_setup", 32'({v1_s1, v1_s2, v1_a}), 32'b010);
        ser = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ser = {ser[6:0], v1_a};
        end
        check("i1_serial", 32'(ser), 32'hC0);
        tick();
        check("i1_done_idle", 32'({v1_done, v1_ready, v1_busy, v1_a}), 32'b1100);
        tick();
        check("i1_done_once", 32'(v1_done), 32'd0);

        // Flush in the 4th SHIFT cycle of F0 on channel B
        in_valid = 1'b1; in_ch = 2'b01; in_data = 8'hF0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_pre_a", 32'(a), 32'd1);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_outs", 32'({a, busy, in_ready, done}), 32'b0010);
        check("flush_sel", 32'({s1, s2}), 32'b01);
        tick();
        check("flush_nodone", 32'({done, a}), 32'b00);
        send0(2'b01, 8'h3C, 8'h3C, 2'b00, 8'h00, 1'b0);

        // Asynchronous reset mid-SHIFT on channel D, data 55
        in_valid = 1'b1; in_ch = 2'b11; in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        @(posedge clk);
        #2;
        check("pre_rst", 32'({a, s1, s2, busy}), 32'b1111);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst", 32'({a, s1, s2, busy, done, in_ready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst", 32'({in_ready, done, busy}), 32'b100);
        send0(2'b10, 8'h81, 8'h81, 2'b00, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
